// File: rtl/sample_fifo.sv
// sample_fifo: synchronous first-word-fall-through sample FIFO between DSP stages.
//   clock        rising-edge clock
//   reset        synchronous, active-high
//   din/wr_en    producer write port; full/almost_full registered back-pressure
//   dout/rd_en   consumer read port; dout shows the head whenever empty==0
//   count        registered occupancy
//   overflow     sticky: write attempted while full
//   underflow    sticky: read attempted while empty
module sample_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned AF_LEVEL   = 12
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [DATA_WIDTH-1:0]         din,
    input  logic                          wr_en,
    output logic                          full,
    output logic                          almost_full,
    output logic [DATA_WIDTH-1:0]         dout,
    input  logic                          rd_en,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  wr_ok;
    logic                  rd_ok;
    logic [CW-1:0]         count_nxt;

    // Accept decisions use the flags held before the edge.
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    // FWFT head: no output register, head drops as soon as rd_ptr advances.
    assign dout = mem[rd_ptr];

    // Next occupancy; simultaneous accepted read+write leaves it unchanged.
    always_comb begin
        count_nxt = count;
        case ({wr_ok, rd_ok})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // Storage array; contents survive reset, writes ignored on the reset cycle.
    always_ff @(posedge clock) begin
        if (!reset && wr_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers, occupancy, flags and sticky error bits.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            almost_full <= (AF_LEVEL == 0);
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count       <= count_nxt;
            empty       <= (count_nxt == '0);
            full        <= (count_nxt == CW'(FIFO_DEPTH));
            almost_full <= (count_nxt >= CW'(AF_LEVEL));
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sample_fifo.sv
// Bench for sample_fifo: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a queue-based model.
module tb_sample_fifo;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AF    = 12;

    logic          clock;
    logic          reset;
    logic [DW-1:0] din;
    logic          wr_en;
    logic          full;
    logic          almost_full;
    logic [DW-1:0] dout;
    logic          rd_en;
    logic          empty;
    logic [4:0]    count;
    logic          overflow;
    logic          underflow;

    int errors = 0;
    int checks = 0;

    sample_fifo #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .AF_LEVEL   (AF)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .din         (din),
        .wr_en       (wr_en),
        .full        (full),
        .almost_full (almost_full),
        .dout        (dout),
        .rd_en       (rd_en),
        .empty       (empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of stored samples plus the two sticky bits.
    logic [DW-1:0] q[$];
    bit            m_ovf = 1'b0;
    bit            m_unf = 1'b0;
    bit            model_valid = 1'b0;

    always @(posedge clock) begin
        if (reset) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            bit was_full;
            bit was_empty;
            was_full  = (q.size() == DEPTH);
            was_empty = (q.size() == 0);
            if (wr_en && was_full)  m_ovf = 1'b1;
            if (rd_en && was_empty) m_unf = 1'b1;
            if (rd_en && !was_empty) void'(q.pop_front());
            if (wr_en && !was_full)  q.push_back(din);
        end
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge clock) begin
        if (model_valid) begin
            chk("m_count", 32'(count), 32'(q.size()));
            chk("m_empty", 32'(empty), 32'(q.size() == 0));
            chk("m_full", 32'(full), 32'(q.size() == DEPTH));
            chk("m_afull", 32'(almost_full), 32'(q.size() >= AF));
            chk("m_ovf", 32'(overflow), 32'(m_ovf));
            chk("m_unf", 32'(underflow), 32'(m_unf));
            if (q.size() != 0) chk("m_dout", dout, q[0]);
        end
    end

    // One clock of stimulus, returning at the following falling edge.
    task automatic cyc(input bit r, input bit w, input bit rd, input logic [31:0] d);
        reset = r;
        wr_en = w;
        rd_en = rd;
        din   = d;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic fill16();
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 1'b0, 32'(i + 1));
    endtask

    initial begin
        reset = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = '0;
        @(negedge clock);
        do_reset();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_afull", 32'(almost_full), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_unf", 32'(underflow), 32'd0);

        // Fill to full, watching almost_full come on at 12.
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 32'(i + 1));
            chk("fill_afull", 32'(almost_full), 32'((i + 1) >= 12));
        end
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd16);
        cyc(1'b0, 1'b1, 1'b0, 32'hDEAD);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd16);
        chk("ovf_head", dout, 32'h1);

        // Drain in order, then one read too many.
        for (int i = 0; i < 16; i++) begin
            chk("drain_dout", dout, 32'(i + 1));
            cyc(1'b0, 1'b0, 1'b1, 32'h0);
        end
        chk("drain_empty", 32'(empty), 32'd1);
        cyc(1'b0, 1'b0, 1'b1, 32'h0);
        chk("unf_set", 32'(underflow), 32'd1);
        chk("unf_count", 32'(count), 32'd0);

        // Simultaneous on empty: write wins, read flagged.
        do_reset();
        cyc(1'b0, 1'b1, 1'b1, 32'hA5);
        chk("se_count", 32'(count), 32'd1);
        chk("se_unf", 32'(underflow), 32'd1);
        chk("se_dout", dout, 32'hA5);

        // Simultaneous on full: read wins, write flagged and dropped.
        do_reset();
        fill16();
        cyc(1'b0, 1'b1, 1'b1, 32'hBEEF);
        chk("sf_count", 32'(count), 32'd15);
        chk("sf_ovf", 32'(overflow), 32'd1);
        for (int i = 0; i < 15; i++) begin
            chk("sf_dout", dout, 32'(i + 2));
            cyc(1'b0, 1'b0, 1'b1, 32'h0);
        end
        chk("sf_empty", 32'(empty), 32'd1);

        // Steady state at 8 across pointer wrap.
        do_reset();
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b0, 32'(i + 1));
        for (int i = 0; i < 40; i++) begin
            chk("ss_dout", dout, 32'(i + 1));
            cyc(1'b0, 1'b1, 1'b1, 32'(i + 9));
            chk("ss_count", 32'(count), 32'd8);
        end
        chk("ss_head", dout, 32'd41);

        // Reset mid-operation with overflow set and a write on the reset cycle.
        do_reset();
        fill16();
        cyc(1'b0, 1'b1, 1'b0, 32'h99);
        for (int i = 0; i < 11; i++) cyc(1'b0, 1'b0, 1'b1, 32'h0);
        chk("r6_count", 32'(count), 32'd5);
        chk("r6_ovf", 32'(overflow), 32'd1);
        cyc(1'b1, 1'b1, 1'b0, 32'h77);
        chk("r6_rcount", 32'(count), 32'd0);
        chk("r6_rempty", 32'(empty), 32'd1);
        chk("r6_rovf", 32'(overflow), 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 32'h100);
        cyc(1'b0, 1'b1, 1'b0, 32'h101);
        chk("r6_first", dout, 32'h100);

        // Randomized traffic with alternating fill/drain bias and rare resets.
        for (int i = 0; i < 3000; i++) begin
            int pw;
            pw = ((i / 100) % 2 == 0) ? 75 : 25;
            cyc(($urandom_range(0, 199) == 0),
                ($urandom_range(0, 99) < pw),
                ($urandom_range(0, 99) < (100 - pw)),
                $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
